inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end for the pipelined ARM core. Owns the program counter and drives the address side of the combinational instruction memory, so it is the requester half of that memory interface. Captures each returned word together with its PC+4 into a small FIFO prefetch buffer and presents them to decode through a valid/ready handshake. Accepts branch redirects from execute, which flush the buffer.

## Interface
- RESET_PC, 32'd0: byte address fetched first after reset.
- DEPTH, 2: prefetch buffer entries; power of two, 2..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch_taken  in  1  redirect request from execute; sampled each rising edge.
- branch_addr  in  32  redirect target byte address; bits [1:0] ignored and treated as 0.
- imem_adr  out  32  byte address presented to the instruction memory; equals the PC register.
- imem_inst  in  32  instruction word returned combinationally for imem_adr in the same cycle.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction word.
- out_pc_plus4  out  32  head entry's fetch address + 4.

## Operation
- State:
  - pc[31:0]
  - circular buffer of DEPTH entries, each {inst, pc_plus4}
  - rd_ptr, wr_ptr, count (0..DEPTH).
- deq = out_valid & out_ready.
- fetch_fire = !branch_taken & ((count < DEPTH) | deq).
- On fetch_fire:
  - write {imem_inst, pc+4} at wr_ptr;
  - wr_ptr++;
  - pc <= pc + 4.
- On deq with !branch_taken: rd_ptr++.
- count update:
  - fire & !deq: +1
  - deq & !fire: -1
  - both or neither: unchanged.
- Full buffer with deq in the same cycle: fetch proceeds. The freed slot is reused in that cycle, so count stays DEPTH.
- Branch (branch_taken=1):
  - pc <= {branch_addr[31:2],2'b00};
  - rd_ptr, wr_ptr and count cleared to 0;
  - no fetch is written and the imem_inst for that cycle is discarded;
  - a simultaneous deq still completes from decode's view, but the cleared buffer makes its pointer advance irrelevant.
  - Branch takes priority over every other event.
- Output derivation:
  - out_valid = (count != 0).
  - out_inst and out_pc_plus4 are read from the head entry (registered storage, no path from imem_inst).
  - When out_valid=0 both are driven 0.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. The stored pc_plus4 wraps identically.
- Reset (asynchronous, any time, including mid-burst or with a pending branch):
  - pc = RESET_PC, pointers/count = 0;
  - out_valid = 0, out_inst = 0, out_pc_plus4 = 0;
  - imem_adr = RESET_PC immediately.
  - Buffer contents need not be cleared, but must never be visible while count = 0.

## Timing
- imem_adr follows the pc register; it changes only at clock edges or on asynchronous reset.
- Fetch-to-output latency: 1 cycle. A word fetched in cycle N is at the head in cycle N+1 if the buffer was empty.
- Throughput with out_ready held 1: one instruction per cycle, and out_valid stays 1 continuously after the first fetch.
- With out_ready=0: exactly DEPTH fetches occur, then pc and imem_adr hold steady until a deq or a branch.
- Branch asserted in cycle N:
  - out_valid=0 in cycle N+1;
  - imem_adr = target in cycle N+1;
  - the target instruction appears at the head in cycle N+2.
- First cycle after rst_n rises: fetch at RESET_PC. out_valid rises on the following cycle.

## Test plan
- **Reset/stream:** hold out_ready=1 after reset, memory returns word = address.
  - Head sequence is inst 0,4,8,… with out_pc_plus4 4,8,12,….
  - out_valid=1 from the 2nd cycle on.
- **Backpressure:** out_ready=0 for 6 cycles with DEPTH=2.
  - Exactly 2 fetches (imem_adr 0→4→8), then imem_adr holds 8 and count holds 2.
  - Raising out_ready drains 0, 4, then 8 with no gap or duplicate.
- **Full plus dequeue:** full buffer, out_ready=1 for one cycle.
  - A fetch happens in the same cycle and count stays 2.
  - Order is preserved.
- **Branch:** branch_taken=1, branch_addr=32'h0000_0093 while the buffer is full and out_ready=1.
  - Next cycle: out_valid=0 and imem_adr=32'h90.
  - Following cycle: head inst = word@0x90, out_pc_plus4=32'h94.
  - No stale entry ever appears.
- **Wrap:** RESET_PC=32'hFFFF_FFF8.
  - Fetch addresses FFFFFFF8, FFFFFFFC, 0.
  - Second entry carries out_pc_plus4=0.
- **Async reset:** drop rst_n mid-cycle during streaming.
  - out_valid, out_inst and out_pc_plus4 go 0 and imem_adr=RESET_PC before the next clock edge.
  - Streaming resumes from RESET_PC after release.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end with prefetch FIFO
// Owns the PC, drives combinational imem and buffers {inst, pc+4} toward decode.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic [31:0] imem_adr,
   input  logic [31:0] imem_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc_plus4
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   pc_next4;
   logic [31:0]   inst_q [DEPTH];
   logic [31:0]   pc4_q  [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW:0]   count;
   logic          deq;
   logic          fetch_fire;
   logic          unused_adr_bits;

   assign unused_adr_bits = ^branch_addr[1:0];

   assign pc_next4   = pc + 32'd4;
   assign imem_adr   = pc;
   assign out_valid  = (count != '0);
   assign deq        = out_valid & out_ready;
   // A full buffer still fetches when the head leaves this cycle: the slot is reused.
   assign fetch_fire = !branch_taken & ((count != FULL) | deq);

   assign out_inst     = out_valid ? inst_q[rd_ptr] : 32'd0;
   assign out_pc_plus4 = out_valid ? pc4_q[rd_ptr]  : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (branch_taken) begin
         pc     <= {branch_addr[31:2], 2'b00};
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (fetch_fire) begin
            pc     <= pc_next4;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         if (fetch_fire && !deq)
            count <= count + (PW+1)'(1);
         else if (deq && !fetch_fire)
            count <= count - (PW+1)'(1);
      end
   end

   // Storage is never reset; out_valid gating hides stale contents.
   always_ff @(posedge clk) begin
      if (fetch_fire) begin
         inst_q[wr_ptr] <= imem_inst;
         pc4_q[wr_ptr]  <= pc_next4;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n, rst2_n;
   logic        branch_taken, branch2;
   logic [31:0] branch_addr, branch_addr2;
   logic [31:0] imem_adr, imem_inst, imem_adr2, imem_inst2;
   logic        out_valid, out_ready, out_valid2, out_ready2;
   logic [31:0] out_inst, out_pc_plus4, out_inst2, out_pc_plus42;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] wd(input logic [31:0] a);
      return a ^ 32'hE500_0000;
   endfunction

   assign imem_inst  = wd(imem_adr);
   assign imem_inst2 = wd(imem_adr2);

   inst_fetch_unit #(.RESET_PC(32'd0), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_addr(branch_addr),
      .imem_adr(imem_adr), .imem_inst(imem_inst), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_pc_plus4(out_pc_plus4));

   inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .branch_taken(branch2), .branch_addr(branch_addr2),
      .imem_adr(imem_adr2), .imem_inst(imem_inst2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_inst(out_inst2), .out_pc_plus4(out_pc_plus42));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic head(input string tag, input logic v, input logic [31:0] a, input logic [31:0] adr);
      chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, "_inst"}, out_inst, v ? wd(a) : 32'd0);
      chk({tag, "_pc4"}, out_pc_plus4, v ? a + 32'd4 : 32'd0);
      chk({tag, "_adr"}, imem_adr, adr);
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      branch_taken = 1'b0; branch_addr = 32'd0;
      branch2 = 1'b0; branch_addr2 = 32'd0;
      out_ready = 1'b1; out_ready2 = 1'b1;

      // reset state
      #3;
      head("rst", 1'b0, 32'd0, 32'd0);
      tick;
      rst_n = 1'b1;

      // streaming with out_ready=1
      for (int n = 1; n <= 5; n++) begin
         tick;
         head($sformatf("stream%0d", n), 1'b1, 32'(4*(n-1)), 32'(4*n));
      end

      // async reset mid-cycle
      rst_n = 1'b0;
      #1;
      head("async", 1'b0, 32'd0, 32'd0);
      out_ready = 1'b0;
      tick;
      head("async_hold", 1'b0, 32'd0, 32'd0);
      rst_n = 1'b1;

      // backpressure: exactly two fetches then hold
      tick; head("bp1", 1'b1, 32'd0, 32'd4);
      tick; head("bp2", 1'b1, 32'd0, 32'd8);
      for (int n = 3; n <= 6; n++) begin
         tick; head($sformatf("bp%0d", n), 1'b1, 32'd0, 32'd8);
      end

      // full buffer with a dequeue: fetch proceeds in the same cycle
      out_ready = 1'b1;
      tick; head("fulldeq", 1'b1, 32'd4, 32'd12);
      out_ready = 1'b0;
      tick; head("fullhold", 1'b1, 32'd4, 32'd12);
      out_ready = 1'b1;
      tick; head("drain8", 1'b1, 32'd8, 32'd16);
      tick; head("drain12", 1'b1, 32'd12, 32'd20);

      // branch with full buffer and out_ready=1
      branch_taken = 1'b1;
      branch_addr  = 32'h0000_0093;
      tick; head("br_flush", 1'b0, 32'd0, 32'h90);
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      tick; head("br_tgt", 1'b1, 32'h90, 32'h94);
      tick; head("br_next", 1'b1, 32'h94, 32'h98);

      // PC wrap on the second instance
      chk("wrap_rst_adr", imem_adr2, 32'hFFFF_FFF8);
      chk("wrap_rst_valid", {31'd0, out_valid2}, 32'd0);
      rst2_n = 1'b1;
      tick;
      chk("wrap1_inst", out_inst2, wd(32'hFFFF_FFF8));
      chk("wrap1_pc4", out_pc_plus42, 32'hFFFF_FFFC);
      chk("wrap1_adr", imem_adr2, 32'hFFFF_FFFC);
      tick;
      chk("wrap2_inst", out_inst2, wd(32'hFFFF_FFFC));
      chk("wrap2_pc4", out_pc_plus42, 32'd0);
      chk("wrap2_adr", imem_adr2, 32'd0);
      tick;
      chk("wrap3_inst", out_inst2, wd(32'd0));
      chk("wrap3_pc4", out_pc_plus42, 32'd4);
      chk("wrap3_valid", {31'd0, out_valid2}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
